// File: rtl/rotation_motor_driver_if.sv
// Command/drive bundle between the rotation controller and the stepper driver.
// Commands are plain levels (no valid/ready): the driver samples left/right every clock.
interface rotation_motor_driver_if #(
  parameter int POS_W = 8
);
  logic             left;
  logic             right;
  logic [3:0]       phase;
  logic             step_pulse;
  logic [POS_W-1:0] heading;
  logic             moving;
  logic             fault;

  modport master (
    output left, right,
    input  phase, step_pulse, heading, moving, fault
  );

  modport slave (
    input  left, right,
    output phase, step_pulse, heading, moving, fault
  );
endinterface

// File: rtl/rotation_motor_driver.sv
// 4-phase stepper driver: paces one-hot coil steps from left/right level commands,
// inserts coils-off dead time on reversals and keeps a wrapping heading count.
module rotation_motor_driver #(
  parameter int STEP_DIV  = 4,
  parameter int DEAD_TIME = 2,
  parameter int POS_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  rotation_motor_driver_if.slave  bus,
  output logic [1:0]              state_o
);

  localparam int DIV_W  = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
  localparam int DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(STEP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_TIME - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN_L = 2'd1,
    S_RUN_R = 2'd2,
    S_DEAD  = 2'd3
  } state_e;

  state_e             state_q, state_d, target;
  logic [1:0]         idx_q, idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DEAD_W-1:0]  dead_q, dead_d;
  logic [POS_W-1:0]   heading_q, heading_d;
  logic               step_q, step_d;
  logic               fault_q, fault_d;
  logic               cmd_l, cmd_r, moving;

  // Both commands at once are illegal: the FSM sees NONE, fault records it.
  assign cmd_l = bus.left & ~bus.right;
  assign cmd_r = bus.right & ~bus.left;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      div_q     <= '0;
      dead_q    <= '0;
      heading_q <= '0;
      step_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      dead_q    <= dead_d;
      heading_q <= heading_d;
      step_q    <= step_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    div_d     = div_q;
    dead_d    = dead_q;
    heading_d = heading_q;
    step_d    = 1'b0;
    fault_d   = bus.left & bus.right;
    target    = cmd_l ? S_RUN_L : (cmd_r ? S_RUN_R : S_IDLE);

    case (state_q)
      S_IDLE: begin
        state_d = target;
        div_d   = '0;
      end
      S_RUN_L, S_RUN_R: begin
        if ((state_q == S_RUN_L && cmd_l) || (state_q == S_RUN_R && cmd_r)) begin
          if (div_q == DIV_MAX) begin
            div_d  = '0;
            step_d = 1'b1;
            if (state_q == S_RUN_L) begin
              idx_d     = idx_q + 2'd1;
              heading_d = heading_q + POS_W'(1);
            end else begin
              idx_d     = idx_q - 2'd1;
              heading_d = heading_q - POS_W'(1);
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end else if (cmd_l || cmd_r) begin
          // Opposite command: coils off before reversing; idx/heading are kept.
          state_d = S_DEAD;
          dead_d  = DEAD_MAX;
          div_d   = '0;
        end else begin
          state_d = S_IDLE;
          div_d   = '0;
        end
      end
      S_DEAD: begin
        if (dead_q == '0) begin
          state_d = target;
          div_d   = '0;
        end else begin
          dead_d = dead_q - DEAD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign moving         = (state_q == S_RUN_L) || (state_q == S_RUN_R);
  assign bus.moving     = moving;
  assign bus.phase      = moving ? (4'b0001 << idx_q) : 4'b0000;
  assign bus.step_pulse = step_q;
  assign bus.heading    = heading_q;
  assign bus.fault      = fault_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_rotation_motor_driver.sv
// Directed bench for rotation_motor_driver (STEP_DIV=4, DEAD_TIME=2, POS_W=8).
module tb_rotation_motor_driver;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_cmp;
  int         n_err;
  int         n_steps;
  logic [3:0] exp_ph[4];
  logic [7:0] exp_hd[4];

  rotation_motor_driver_if #(.POS_W(8)) bus ();

  rotation_motor_driver #(
    .STEP_DIV  (4),
    .DEAD_TIME (2),
    .POS_W     (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.step_pulse) n_steps++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.left = 1'b0;
    bus.right = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_steps = 0;

    // Reset values
    do_reset();
    chk("rst_phase", 32'(bus.phase), 32'h0);
    chk("rst_step", 32'(bus.step_pulse), 32'h0);
    chk("rst_heading", 32'(bus.heading), 32'h0);
    chk("rst_moving", 32'(bus.moving), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);

    // Test 1: left for 13 cycles
    bus.left = 1'b1;
    n_steps = 0;
    tick(1);
    chk("t1_moving", 32'(bus.moving), 32'h1);
    chk("t1_phase0", 32'(bus.phase), 32'h1);
    tick(3);
    chk("t1_nostep_yet", 32'(bus.phase), 32'h1);
    tick(1);
    chk("t1_phase1", 32'(bus.phase), 32'h2);
    chk("t1_pulse1", 32'(bus.step_pulse), 32'h1);
    tick(1);
    chk("t1_pulse_one_cycle", 32'(bus.step_pulse), 32'h0);
    tick(3);
    chk("t1_phase2", 32'(bus.phase), 32'h4);
    tick(4);
    chk("t1_phase3", 32'(bus.phase), 32'h8);
    chk("t1_heading", 32'(bus.heading), 32'h3);
    chk("t1_npulses", 32'(n_steps), 32'd3);

    // Test 2: reversal with dead time
    bus.left = 1'b0;
    bus.right = 1'b1;
    tick(1);
    chk("t2_dead1_phase", 32'(bus.phase), 32'h0);
    chk("t2_dead1_moving", 32'(bus.moving), 32'h0);
    chk("t2_dead1_state", 32'(state_dbg), 32'h3);
    tick(1);
    chk("t2_dead2_phase", 32'(bus.phase), 32'h0);
    chk("t2_dead2_moving", 32'(bus.moving), 32'h0);
    tick(1);
    chk("t2_run_phase", 32'(bus.phase), 32'h8);
    chk("t2_run_moving", 32'(bus.moving), 32'h1);
    chk("t2_run_heading", 32'(bus.heading), 32'h3);
    tick(4);
    chk("t2_step1_phase", 32'(bus.phase), 32'h4);
    chk("t2_step1_heading", 32'(bus.heading), 32'h2);
    tick(4);
    chk("t2_step2_phase", 32'(bus.phase), 32'h2);
    chk("t2_step2_heading", 32'(bus.heading), 32'h1);

    // Test 3: right from reset, heading wraps downwards
    do_reset();
    exp_ph[0] = 4'b1000; exp_hd[0] = 8'hFF;
    exp_ph[1] = 4'b0100; exp_hd[1] = 8'hFE;
    exp_ph[2] = 4'b0010; exp_hd[2] = 8'hFD;
    exp_ph[3] = 4'b0001; exp_hd[3] = 8'hFC;
    bus.right = 1'b1;
    tick(1);
    chk("t3_start_phase", 32'(bus.phase), 32'h1);
    for (int s = 0; s < 4; s++) begin
      tick(4);
      chk($sformatf("t3_phase%0d", s), 32'(bus.phase), 32'(exp_ph[s]));
      chk($sformatf("t3_heading%0d", s), 32'(bus.heading), 32'(exp_hd[s]));
    end

    // Test 4: illegal command during RUN_L at heading 2
    do_reset();
    bus.left = 1'b1;
    tick(9);
    chk("t4_pre_heading", 32'(bus.heading), 32'h2);
    bus.right = 1'b1;
    n_steps = 0;
    tick(1);
    chk("t4_fault", 32'(bus.fault), 32'h1);
    chk("t4_phase_off", 32'(bus.phase), 32'h0);
    chk("t4_state_idle", 32'(state_dbg), 32'h0);
    chk("t4_heading", 32'(bus.heading), 32'h2);
    chk("t4_nostep", 32'(n_steps), 32'd0);
    bus.left = 1'b0;
    bus.right = 1'b0;
    tick(1);
    chk("t4_fault_clear", 32'(bus.fault), 32'h0);

    // Test 5: reset mid-run at heading 5
    do_reset();
    bus.left = 1'b1;
    tick(21);
    chk("t5_pre_heading", 32'(bus.heading), 32'h5);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_phase", 32'(bus.phase), 32'h0);
    chk("t5_rst_heading", 32'(bus.heading), 32'h0);
    chk("t5_rst_moving", 32'(bus.moving), 32'h0);
    chk("t5_rst_step", 32'(bus.step_pulse), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("t5_restart_phase", 32'(bus.phase), 32'h1);
    tick(4);
    chk("t5_restart_step_phase", 32'(bus.phase), 32'h2);
    chk("t5_restart_heading", 32'(bus.heading), 32'h1);

    // Test 6: drop left at divider=2, resume at retained idx
    tick(2);
    bus.left = 1'b0;
    n_steps = 0;
    tick(1);
    chk("t6_idle_phase", 32'(bus.phase), 32'h0);
    chk("t6_idle_nostep", 32'(n_steps), 32'd0);
    chk("t6_idle_heading", 32'(bus.heading), 32'h1);
    bus.left = 1'b1;
    tick(1);
    chk("t6_resume_phase", 32'(bus.phase), 32'h2);
    tick(3);
    chk("t6_full_period_nostep", 32'(n_steps), 32'd0);
    tick(1);
    chk("t6_step_phase", 32'(bus.phase), 32'h4);
    chk("t6_step_pulse", 32'(bus.step_pulse), 32'h1);
    chk("t6_step_heading", 32'(bus.heading), 32'h2);

    // Upward wrap: 256 left steps from reset returns heading to 0
    do_reset();
    bus.left = 1'b1;
    tick(1 + 255 * 4);
    chk("wrap_heading_ff", 32'(bus.heading), 32'hFF);
    tick(4);
    chk("wrap_heading_00", 32'(bus.heading), 32'h0);
    chk("wrap_phase", 32'(bus.phase), 32'h1);
    bus.left = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
